regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 125 ++++++++++++
 tb/tb_regfile_mp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Multi-ported register file with two combinational read ports, two write
//   ports (port 1 has priority on an address collision) and a pending-write
//   scoreboard. After reset, a self-clearing sequence walks every entry and
//   zeroes it. The block accepts traffic only once that sequence has finished.
//   Register 0 is hardwired to zero and is never busy.
//
// Parameters
//   XLEN   data width of each register
//   NREGS  register count (power of two, >= 4)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rd_addr_a/b -> rd_data_a/b    combinational reads with write bypass
//   wr0_en/addr/data              write port 0
//   wr1_en/addr/data              write port 1 (wins over port 0)
//   iss_en/iss_addr               mark a register as pending write
//   busy_a/b                      pending status of the read addresses
//   ready                         clear sequence done, block accepts traffic
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rd_addr_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_data_a,
  output logic [XLEN-1:0] rd_data_b,
  input  logic            wr0_en,
  input  logic [AW-1:0]   wr0_addr,
  input  logic [XLEN-1:0] wr0_data,
  input  logic            wr1_en,
  input  logic [AW-1:0]   wr1_addr,
  input  logic [XLEN-1:0] wr1_data,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  output logic            busy_a,
  output logic            busy_b,
  output logic            ready
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]      r_state;
  logic [AW-1:0]   r_ptr;
  logic [NREGS-1:0] r_pend;
  logic [XLEN-1:0] r_regs [NREGS];

  logic w_ready;
  logic w_wr0_ok;
  logic w_wr1_ok;
  logic w_iss_ok;

  assign w_ready  = (r_state == RUN);
  assign ready    = w_ready;

  // Every write/issue is qualified by RUN and by a non-zero address, which
  // is what keeps register 0 constant and never pending.
  assign w_wr0_ok = w_ready && wr0_en && (wr0_addr != '0);
  assign w_wr1_ok = w_ready && wr1_en && (wr1_addr != '0);
  assign w_iss_ok = w_ready && iss_en && (iss_addr != '0);

  // Read value seen by a port: bypass from an in-flight write (port 1 first),
  // otherwise the stored entry. Zero before ready and for address 0.
  function automatic logic [XLEN-1:0] read_mux(input logic [AW-1:0] addr);
    logic [XLEN-1:0] v;
    v = '0;
    if (w_ready && (addr != '0)) begin
      if (w_wr1_ok && (wr1_addr == addr))      v = wr1_data;
      else if (w_wr0_ok && (wr0_addr == addr)) v = wr0_data;
      else                                     v = r_regs[addr];
    end
    return v;
  endfunction

  // A register being written this cycle is not reported busy, matching the
  // bypassed data the same port is returning.
  function automatic logic busy_of(input logic [AW-1:0] addr);
    logic hit;
    hit = (w_wr1_ok && (wr1_addr == addr)) || (w_wr0_ok && (wr0_addr == addr));
    return w_ready && (addr != '0) && r_pend[addr] && !hit;
  endfunction

  always_comb begin
    rd_data_a = read_mux(rd_addr_a);
    rd_data_b = read_mux(rd_addr_b);
    busy_a    = busy_of(rd_addr_a);
    busy_b    = busy_of(rd_addr_b);
  end

  // Control: state, clear pointer and scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_pend  <= '0;
    end else if (r_state == CLEAR) begin
      r_ptr <= r_ptr + AW'(1);
      if (r_ptr == AW'(NREGS - 1)) r_state <= RUN;
    end else begin
      // Clears first, set last: an issue in the same cycle as a write to the
      // same register leaves it pending.
      if (w_wr0_ok) r_pend[wr0_addr] <= 1'b0;
      if (w_wr1_ok) r_pend[wr1_addr] <= 1'b0;
      if (w_iss_ok) r_pend[iss_addr] <= 1'b1;
    end
  end

  // Storage: zeroed entry by entry during CLEAR; the port 1 assignment comes
  // last so it overrides port 0 on a shared address.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_regs[r_ptr] <= '0;
    end else begin
      if (w_wr0_ok) r_regs[wr0_addr] <= wr0_data;
      if (w_wr1_ok) r_regs[wr1_addr] <= wr1_data;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A: XLEN=32, NREGS=32 ----------------
  logic        a_rst;
  logic [4:0]  a_rda, a_rdb, a_w0a, a_w1a, a_isa;
  logic [31:0] a_da, a_db, a_w0d, a_w1d;
  logic        a_w0e, a_w1e, a_ise, a_ba, a_bb, a_rdy;

  regfile_mp #(.XLEN(32), .NREGS(32)) u_a (
    .clk(clk), .rst(a_rst),
    .rd_addr_a(a_rda), .rd_addr_b(a_rdb),
    .rd_data_a(a_da), .rd_data_b(a_db),
    .wr0_en(a_w0e), .wr0_addr(a_w0a), .wr0_data(a_w0d),
    .wr1_en(a_w1e), .wr1_addr(a_w1a), .wr1_data(a_w1d),
    .iss_en(a_ise), .iss_addr(a_isa),
    .busy_a(a_ba), .busy_b(a_bb), .ready(a_rdy)
  );

  // ---------------- DUT B: XLEN=64, NREGS=16 ----------------
  logic        b_rst;
  logic [3:0]  b_rda, b_rdb, b_w0a, b_w1a, b_isa;
  logic [63:0] b_da, b_db, b_w0d, b_w1d;
  logic        b_w0e, b_w1e, b_ise, b_ba, b_bb, b_rdy;

  regfile_mp #(.XLEN(64), .NREGS(16)) u_b (
    .clk(clk), .rst(b_rst),
    .rd_addr_a(b_rda), .rd_addr_b(b_rdb),
    .rd_data_a(b_da), .rd_data_b(b_db),
    .wr0_en(b_w0e), .wr0_addr(b_w0a), .wr0_data(b_w0d),
    .wr1_en(b_w1e), .wr1_addr(b_w1a), .wr1_data(b_w1d),
    .iss_en(b_ise), .iss_addr(b_isa),
    .busy_a(b_ba), .busy_b(b_bb), .ready(b_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then move 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_rda = '0; a_rdb = '0;
    a_w0e = 1'b0; a_w0a = '0; a_w0d = '0;
    a_w1e = 1'b0; a_w1a = '0; a_w1d = '0;
    a_ise = 1'b0; a_isa = '0;
    b_rst = 1'b1; b_rda = '0; b_rdb = '0;
    b_w0e = 1'b0; b_w0a = '0; b_w0d = '0;
    b_w1e = 1'b0; b_w1a = '0; b_w1d = '0;
    b_ise = 1'b0; b_isa = '0;

    // ---- reset state ----
    step();
    a_rda = 5'd5; a_rdb = 5'd0;
    settle();
    chk("a_rst_ready", a_rdy, 0);
    chk("a_rst_rda", a_da, 0);
    chk("a_rst_rdb", a_db, 0);
    chk("a_rst_busya", a_ba, 0);
    chk("a_rst_busyb", a_bb, 0);

    // ---- clear sequence: ready rises after exactly 32 edges ----
    a_rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      chk($sformatf("a_clr_ready_e%0d", i), a_rdy, (i == 32) ? 1 : 0);
    end

    // ---- all 32 registers read zero ----
    for (int i = 0; i < 32; i++) begin
      a_rda = 5'(i); a_rdb = 5'(31 - i);
      settle();
      chk($sformatf("a_zero_a%0d", i), a_da, 0);
      chk($sformatf("a_zero_b%0d", i), a_db, 0);
    end

    // ---- bypass then storage readback on reg 5 ----
    a_w0e = 1'b1; a_w0a = 5'd5; a_w0d = 32'hDEADBEEF; a_rda = 5'd5;
    settle();
    chk("a_byp5", a_da, 32'hDEADBEEF);
    step();
    a_w0e = 1'b0;
    settle();
    chk("a_stor5", a_da, 32'hDEADBEEF);

    // ---- same-address collision: port 1 wins ----
    a_w0e = 1'b1; a_w0a = 5'd7; a_w0d = 32'h11;
    a_w1e = 1'b1; a_w1a = 5'd7; a_w1d = 32'h22; a_rdb = 5'd7;
    settle();
    chk("a_byp7", a_db, 32'h22);
    step();
    a_w0e = 1'b0; a_w1e = 1'b0;
    settle();
    chk("a_stor7", a_db, 32'h22);

    // ---- two different addresses commit together ----
    a_w0e = 1'b1; a_w0a = 5'd10; a_w0d = 32'hA0A0;
    a_w1e = 1'b1; a_w1a = 5'd11; a_w1d = 32'hB1B1;
    step();
    a_w0e = 1'b0; a_w1e = 1'b0; a_rda = 5'd10; a_rdb = 5'd11;
    settle();
    chk("a_dual10", a_da, 32'hA0A0);
    chk("a_dual11", a_db, 32'hB1B1);

    // ---- writes to register 0 are dropped ----
    a_w0e = 1'b1; a_w0a = 5'd0; a_w0d = 32'hFF; a_rda = 5'd0;
    settle();
    chk("a_r0_byp", a_da, 0);
    step();
    a_w0e = 1'b0;
    settle();
    chk("a_r0_stor", a_da, 0);

    // ---- scoreboard ----
    a_ise = 1'b1; a_isa = 5'd3; a_rda = 5'd3;
    settle();
    chk("a_busy3_pre", a_ba, 0);
    step();
    settle();
    chk("a_busy3_set", a_ba, 1);
    step();  // re-issue to an already pending register
    a_ise = 1'b0;
    settle();
    chk("a_busy3_reiss", a_ba, 1);
    a_w1e = 1'b1; a_w1a = 5'd3; a_w1d = 32'h33;
    settle();
    chk("a_busy3_wr", a_ba, 0);
    chk("a_byp3", a_da, 32'h33);
    step();
    a_w1e = 1'b0;
    settle();
    chk("a_busy3_clr", a_ba, 0);
    chk("a_stor3", a_da, 32'h33);
    a_ise = 1'b1; a_isa = 5'd3; a_w0e = 1'b1; a_w0a = 5'd3; a_w0d = 32'h44;
    settle();
    chk("a_busy3_isswr_now", a_ba, 0);
    step();
    a_ise = 1'b0; a_w0e = 1'b0;
    settle();
    chk("a_busy3_isswr_next", a_ba, 1);
    chk("a_stor3b", a_da, 32'h44);
    // issue to reg 0 ignored; write to non-pending reg 10 leaves it clear
    a_ise = 1'b1; a_isa = 5'd0; a_w0e = 1'b1; a_w0a = 5'd10; a_w0d = 32'h10;
    step();
    a_ise = 1'b0; a_w0e = 1'b0; a_rdb = 5'd0;
    settle();
    chk("a_busy0", a_bb, 0);
    a_rdb = 5'd10;
    settle();
    chk("a_busy10", a_bb, 0);
    chk("a_stor10", a_db, 32'h10);

    // ---- reset mid-RUN, writes/issues during CLEAR ignored ----
    a_w0e = 1'b1; a_w0a = 5'd9; a_w0d = 32'h55;
    a_ise = 1'b1; a_isa = 5'd4;
    step();
    a_w0e = 1'b0; a_ise = 1'b0; a_rda = 5'd9; a_rdb = 5'd4;
    settle();
    chk("a_stor9", a_da, 32'h55);
    chk("a_busy4", a_bb, 1);
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    a_w0e = 1'b1; a_w0a = 5'd9; a_w0d = 32'h77;
    a_ise = 1'b1; a_isa = 5'd9;
    settle();
    chk("a_rst2_ready", a_rdy, 0);
    chk("a_rst2_rda", a_da, 0);
    chk("a_rst2_busyb", a_bb, 0);
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 32) begin
        a_w0e = 1'b0; a_ise = 1'b0;
      end
      settle();
      chk($sformatf("a_clr2_ready_e%0d", i), a_rdy, (i == 32) ? 1 : 0);
      if (i == 16) chk("a_clr2_rda_mid", a_da, 0);
    end
    a_rdb = 5'd9;
    settle();
    chk("a_clr2_reg9", a_da, 0);
    chk("a_clr2_busy9", a_bb, 0);
    a_rdb = 5'd4;
    settle();
    chk("a_clr2_busy4", a_bb, 0);
    a_rda = 5'd3;
    settle();
    chk("a_clr2_reg3", a_da, 0);

    // ---- DUT B: 64-bit, 16 registers ----
    b_rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("b_clr_ready_e%0d", i), b_rdy, (i == 16) ? 1 : 0);
    end
    b_w1e = 1'b1; b_w1a = 4'd15; b_w1d = 64'h0123456789ABCDEF; b_rda = 4'd15;
    settle();
    chk("b_byp15", b_da, 64'h0123456789ABCDEF);
    step();
    b_w1e = 1'b0; b_rdb = 4'd15;
    settle();
    chk("b_stor15a", b_da, 64'h0123456789ABCDEF);
    chk("b_stor15b", b_db, 64'h0123456789ABCDEF);

    // ---- reset mid-CLEAR restarts the full sequence ----
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("b_clr2_ready_e%0d", i), b_rdy, (i == 16) ? 1 : 0);
    end
    settle();
    chk("b_clr2_reg15", b_da, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
